// File: rtl/nand_sweep_checker.sv
// -----------------------------------------------------------------------------
// nand_sweep_checker
//
// Exhaustive stimulus/response checker for a 2-input NAND gate. The sweep
// drives the combinations {a,b} = 00, 01, 10, 11 in that order. For each one
// it waits SETTLE cycles, then samples the gate output y against ~(a & b).
// Per-combination failures, a mismatch count and a pass flag are reported.
//
// Parameters:
//   SETTLE   idle cycles between driving a/b and sampling y (0..15)
//
// Optional feature (compile-time macro):
//   SWEEP_STOP_ON_ERR_EN  when defined, the first mismatch ends the sweep
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   sweep request, accepted only while idle
//   a, b      out  registered drive to the gate inputs
//   y         in   gate output under test
//   busy      out  high whenever a sweep is in progress (state != IDLE)
//   done      out  one-cycle pulse at the end of a sweep
//   pass      out  1 = no mismatches; held until the next accepted start
//   err_cnt   out  number of mismatching combinations (0..4)
//   fail_vec  out  bit i set when combination i = {a,b} mismatched
// -----------------------------------------------------------------------------
module nand_sweep_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  // Reference model of the gate under test.
  function automatic logic nand_expect(input logic in_a, input logic in_b);
    return ~(in_a & in_b);
  endfunction

  logic [2:0] state_q,    state_d;
  logic [1:0] idx_q,      idx_d;
  logic [3:0] cnt_q,      cnt_d;
  logic       a_q,        a_d;
  logic       b_q,        b_d;
  logic       busy_q,     busy_d;
  logic       done_q,     done_d;
  logic       pass_q,     pass_d;
  logic [2:0] err_cnt_q,  err_cnt_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic       mismatch_s;
  logic       stop_s;

  // Next-state and result-update logic for the sweep FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;

    mismatch_s = (y != nand_expect(a_q, b_q));
`ifdef SWEEP_STOP_ON_ERR_EN
    stop_s = mismatch_s;
`else
    stop_s = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Results are cleared on the accepting edge, first combination is 00.
          state_d    = S_DRIVE;
          idx_d      = 2'd0;
          a_d        = 1'b0;
          b_d        = 1'b0;
          pass_d     = 1'b0;
          err_cnt_d  = 3'd0;
          fail_vec_d = 4'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRIVE: begin
        if (SETTLE_CNT == 4'd0) begin
          state_d = S_SAMPLE;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_CNT;
        end
      end
      S_SETTLE: begin
        // Leaving when the counter reads 1 gives exactly SETTLE cycles here.
        if (cnt_q <= 4'd1) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (mismatch_s) begin
          fail_vec_d[idx_q] = 1'b1;
          if (err_cnt_q < 3'd4) begin
            err_cnt_d = err_cnt_q + 3'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
        end else begin
          fail_vec_d = fail_vec_q;
        end
        if ((idx_q == 2'd3) || stop_s) begin
          // pass must already reflect this last sample in the DONE cycle.
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 3'd0);
        end else begin
          state_d = S_DRIVE;
          idx_d   = idx_q + 2'd1;
          a_d     = idx_d[1];
          b_d     = idx_d[0];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything including results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      cnt_q      <= 4'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= 3'd0;
      fail_vec_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
    end
  end

  assign a        = a_q;
  assign b        = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_nand_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_nand_sweep_checker
//
// Directed bench for nand_sweep_checker with SETTLE = 2. A behavioural gate
// model drives y from a/b in one of several modes (good NAND, stuck-at,
// AND instead of NAND). Expected timing and results are hand-computed.
// -----------------------------------------------------------------------------
module tb_nand_sweep_checker;

  localparam int MODE_NAND   = 0;
  localparam int MODE_STUCK1 = 1;
  localparam int MODE_AND    = 2;
  localparam int MODE_STUCK0 = 3;
  localparam int MODE_X      = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a;
  logic       b;
  logic       y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_vec;

  int mode;
  int n_checks;
  int n_fail;
  int done_seen;

  nand_sweep_checker #(.SETTLE(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_vec (fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate under test, possibly faulty.
  always_comb begin
    case (mode)
      MODE_NAND:   y = ~(a & b);
      MODE_STUCK1: y = 1'b1;
      MODE_AND:    y = a & b;
      MODE_STUCK0: y = 1'b0;
      default:     y = 1'bx;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ab"},   32'({a, b}),  32'd0);
    check_eq({tag, "_busy"}, 32'(busy),    32'd0);
    check_eq({tag, "_done"}, 32'(done),    32'd0);
    check_eq({tag, "_pass"}, 32'(pass),    32'd0);
    check_eq({tag, "_err"},  32'(err_cnt), 32'd0);
    check_eq({tag, "_fvec"}, 32'(fail_vec), 32'd0);
  endtask

  // Raise start for one edge (E0); returns #1 after E0.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Called #1 after E0. Walks the cycles following E0+k for k = 0..done_k+1.
  task automatic sweep_expect(input string tag, input int done_k, input logic [2:0] e_err,
                              input logic [3:0] e_fail, input logic e_pass, input int pulse_k);
    for (int k = 0; k <= done_k + 1; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      start = (k == pulse_k - 1) ? 1'b1 : 1'b0;
      if (k == 0) begin
        check_eq({tag, "_clr_err"},  32'(err_cnt),  32'd0);
        check_eq({tag, "_clr_fvec"}, 32'(fail_vec), 32'd0);
        check_eq({tag, "_clr_pass"}, 32'(pass),     32'd0);
      end
      check_eq($sformatf("%s_done_k%0d", tag, k), 32'(done), 32'((k == done_k) ? 1 : 0));
      check_eq($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'((k <= done_k) ? 1 : 0));
      if (k < done_k) begin
        check_eq($sformatf("%s_ab_k%0d", tag, k), 32'({a, b}), 32'(k / 4));
      end else if (k == done_k) begin
        check_eq({tag, "_err"},  32'(err_cnt),  32'(e_err));
        check_eq({tag, "_fvec"}, 32'(fail_vec), 32'(e_fail));
        check_eq({tag, "_pass"}, 32'(pass),     32'(e_pass));
      end else begin
        check_eq({tag, "_ab_idle"},   32'({a, b}),  32'd0);
        check_eq({tag, "_hold_err"},  32'(err_cnt), 32'(e_err));
        check_eq({tag, "_hold_pass"}, 32'(pass),    32'(e_pass));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    done_seen = 0;
    mode      = MODE_X;
    start     = 1'b0;
    rst_n     = 1'b0;

    // Reset with y unknown.
    #3;
    check_all_zero("rst");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("idle_no_start");

    // Good gate.
    mode = MODE_NAND;
    pulse_start();
    sweep_expect("good", 16, 3'd0, 4'b0000, 1'b1, -100);

    // Stuck-at-1 output: only 11 mismatches.
    mode = MODE_STUCK1;
    pulse_start();
    sweep_expect("stuck1", 16, 3'd1, 4'b1000, 1'b0, -100);

    // AND instead of NAND: every combination mismatches.
    mode = MODE_AND;
    pulse_start();
`ifdef SWEEP_STOP_ON_ERR_EN
    sweep_expect("and", 4, 3'd1, 4'b0001, 1'b0, -100);
`else
    sweep_expect("and", 16, 3'd4, 4'b1111, 1'b0, -100);
`endif

    // Start pulsed at E0+5 is ignored; then a second sweep repeats the result.
    mode = MODE_NAND;
    pulse_start();
    sweep_expect("ign", 16, 3'd0, 4'b0000, 1'b1, 5);
    mode = MODE_AND;
    pulse_start();
`ifdef SWEEP_STOP_ON_ERR_EN
    sweep_expect("and2", 4, 3'd1, 4'b0001, 1'b0, -100);
`else
    sweep_expect("and2", 16, 3'd4, 4'b1111, 1'b0, -100);
`endif
    mode = MODE_NAND;
    pulse_start();
    sweep_expect("rerun", 16, 3'd0, 4'b0000, 1'b1, -100);

    // Stuck-at-0 output: 00, 01, 10 mismatch.
    mode = MODE_STUCK0;
    pulse_start();
`ifdef SWEEP_STOP_ON_ERR_EN
    sweep_expect("stuck0", 4, 3'd1, 4'b0001, 1'b0, -100);
`else
    sweep_expect("stuck0", 16, 3'd3, 4'b0111, 1'b0, -100);
`endif

    // Asynchronous reset mid-sweep, in the cycle following E0+7.
    mode = MODE_AND;
    pulse_start();
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check_eq("abort_no_done", 32'(done_seen), 32'd0);
    check_all_zero("abort_idle");

    // Start held high re-arms in the IDLE cycle after DONE.
    mode  = MODE_NAND;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("rearm_idle_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rearm_busy", 32'(busy), 32'd1);
    check_eq("rearm_clr_pass", 32'(pass), 32'd0);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("rearm_end_pass", 32'(pass), 32'd1);
    check_eq("rearm_end_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
